rggen_axi4lite_initiator: RTL and testbench

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI4-Lite read and write transactions on a `rggen_axi4lite_if` master modport. It is the bus-side driver for rggen-generated register blocks: it sits in testbench harnesses and in SoC glue logic, upstream of any block that exposes `rggen_axi4lite_if.slave`. It returns read data and the AXI response status on a separate valid/ready response stream.

---
 rtl/rggen_axi4lite_initiator_if.sv | 37 +++
 rtl/rggen_axi4lite_initiator.sv | 128 ++++++++++++
 tb/tb_rggen_axi4lite_initiator.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_axi4lite_initiator_if.sv
// AXI4-Lite bus bundle shared by the initiator (master) and rggen register blocks (slave).
interface rggen_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                       awvalid;
    logic                       awready;
    logic [ADDRESS_WIDTH-1:0]   awaddr;
    logic [2:0]                 awprot;
    logic                       wvalid;
    logic                       wready;
    logic [BUS_WIDTH-1:0]       wdata;
    logic [BUS_WIDTH/8-1:0]     wstrb;
    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;
    logic                       arvalid;
    logic                       arready;
    logic [ADDRESS_WIDTH-1:0]   araddr;
    logic [2:0]                 arprot;
    logic                       rvalid;
    logic                       rready;
    logic [BUS_WIDTH-1:0]       rdata;
    logic [1:0]                 rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rggen_axi4lite_initiator.sv
// Single-outstanding AXI4-Lite master: command stream in, AXI read/write out, response stream back.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid and payload
// stay stable until then, and every valid/ready this block drives is decoded from registers only.
module rggen_axi4lite_initiator #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_write,
    output logic [BUS_WIDTH-1:0]     o_rsp_data,
    output logic [1:0]               o_rsp_status,
    output logic [2:0]               o_state,
    rggen_axi4lite_if.master         axi4lite_if
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        WAIT_B   = 3'd2,
        READ     = 3'd3,
        WAIT_R   = 3'd4,
        RESPONSE = 3'd5
    } state_e;

    state_e                     state;
    state_e                     state_next;
    logic                       aw_done;
    logic                       w_done;
    logic                       write_q;
    logic [ADDRESS_WIDTH-1:0]   address_q;
    logic [BUS_WIDTH-1:0]       data_q;
    logic [BUS_WIDTH/8-1:0]     strobe_q;
    logic [BUS_WIDTH-1:0]       rsp_data_q;
    logic [1:0]                 rsp_status_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // AW and W complete independently; a channel counts as done if it finished earlier or now.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_cmd_valid) state_next = i_cmd_write ? WRITE : READ;
            WRITE:    if ((aw_done || axi4lite_if.awready) && (w_done || axi4lite_if.wready))
                          state_next = WAIT_B;
            WAIT_B:   if (axi4lite_if.bvalid) state_next = RESPONSE;
            READ:     if (axi4lite_if.arready) state_next = WAIT_R;
            WAIT_R:   if (axi4lite_if.rvalid) state_next = RESPONSE;
            RESPONSE: if (i_rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
            strobe_q     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        write_q   <= i_cmd_write;
                        address_q <= i_cmd_address;
                        data_q    <= i_cmd_data;
                        strobe_q  <= i_cmd_strobe;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end
                end
                WRITE: begin
                    if (axi4lite_if.awready) aw_done <= 1'b1;
                    if (axi4lite_if.wready)  w_done  <= 1'b1;
                end
                WAIT_B: begin
                    if (axi4lite_if.bvalid) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= axi4lite_if.bresp;
                    end
                end
                WAIT_R: begin
                    if (axi4lite_if.rvalid) begin
                        rsp_data_q   <= axi4lite_if.rdata;
                        rsp_status_q <= axi4lite_if.rresp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready         = (state == IDLE);
    assign o_rsp_valid         = (state == RESPONSE);
    assign o_rsp_write         = write_q;
    assign o_rsp_data          = rsp_data_q;
    assign o_rsp_status        = rsp_status_q;
    assign o_state             = state;

    assign axi4lite_if.awvalid = (state == WRITE) && !aw_done;
    assign axi4lite_if.wvalid  = (state == WRITE) && !w_done;
    assign axi4lite_if.bready  = (state == WAIT_B);
    assign axi4lite_if.arvalid = (state == READ);
    assign axi4lite_if.rready  = (state == WAIT_R);
    assign axi4lite_if.awaddr  = address_q;
    assign axi4lite_if.araddr  = address_q;
    assign axi4lite_if.wdata   = data_q;
    assign axi4lite_if.wstrb   = strobe_q;
    assign axi4lite_if.awprot  = 3'b000;
    assign axi4lite_if.arprot  = 3'b000;
endmodule

// File: tb/tb_rggen_axi4lite_initiator.sv
// Bench for rggen_axi4lite_initiator: scripted AXI4-Lite slave with per-channel delays plus a word memory model.
module tb_rggen_axi4lite_initiator;
    localparam int AW = 16;
    localparam int BW = 32;
    localparam int SW = BW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [BW-1:0] cmd_data;
    logic [SW-1:0] cmd_strobe;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [BW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

    rggen_axi4lite_initiator #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_address (cmd_address),
        .i_cmd_data    (cmd_data),
        .i_cmd_strobe  (cmd_strobe),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_write   (rsp_write),
        .o_rsp_data    (rsp_data),
        .o_rsp_status  (rsp_status),
        .o_state       (state_dbg),
        .axi4lite_if   (bus)
    );

    int errors = 0;
    int checks = 0;

    // slave configuration
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr_val = '0;

    // slave state
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_hi, w_hi;
    logic          aw_got, w_got, b_pend, r_pend, overlap, early_b;
    logic [AW-1:0] aw_a, ar_a;
    logic [BW-1:0] w_d;
    logic [SW-1:0] w_s;
    logic [BW-1:0] smem [64];
    logic          aw_hs, w_hs, both;
    logic [AW-1:0] aw_cur_a;
    logic [BW-1:0] w_cur_d, wr_word;
    logic [SW-1:0] w_cur_s;

    logic [31:0] model_mem [64];

    always_comb begin
        bus.awready = bus.awvalid && !aw_got && (aw_cnt >= aw_delay);
        bus.wready  = bus.wvalid && !w_got && (w_cnt >= w_delay);
        bus.bvalid  = b_pend && (b_cnt >= b_delay);
        bus.bresp   = bresp_cfg;
        bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
        bus.rvalid  = r_pend && (r_cnt >= r_delay);
        bus.rdata   = rd_ovr_en ? rd_ovr_val : smem[ar_a[7:2]];
        bus.rresp   = rresp_cfg;
    end

    always_comb begin
        aw_hs    = bus.awvalid && bus.awready;
        w_hs     = bus.wvalid && bus.wready;
        both     = (aw_got || aw_hs) && (w_got || w_hs);
        aw_cur_a = aw_hs ? bus.awaddr : aw_a;
        w_cur_d  = w_hs ? bus.wdata : w_d;
        w_cur_s  = w_hs ? bus.wstrb : w_s;
        wr_word  = smem[aw_cur_a[7:2]];
        for (int b = 0; b < SW; b++)
            if (w_cur_s[b]) wr_word[8*b +: 8] = w_cur_d[8*b +: 8];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_hi <= 0; w_hi <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            overlap <= 1'b0; early_b <= 1'b0;
            aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
            for (int i = 0; i < 64; i++) smem[i] <= '0;
        end else begin
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            b_cnt  <= (b_pend && !(bus.bvalid && bus.bready)) ? b_cnt + 1 : 0;
            r_cnt  <= (r_pend && !(bus.rvalid && bus.rready)) ? r_cnt + 1 : 0;
            aw_hi  <= aw_hi + (bus.awvalid ? 1 : 0);
            w_hi   <= w_hi + (bus.wvalid ? 1 : 0);
            if (aw_hs) aw_a <= bus.awaddr;
            if (w_hs) begin
                w_d <= bus.wdata;
                w_s <= bus.wstrb;
            end
            if (both) begin
                smem[aw_cur_a[7:2]] <= wr_word;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (bus.bvalid && bus.bready) b_pend <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                r_pend <= 1'b1;
                ar_a   <= bus.araddr;
            end
            if (bus.rvalid && bus.rready) r_pend <= 1'b0;
            if ((bus.arvalid && (b_pend || aw_got || w_got)) || (bus.awvalid && r_pend))
                overlap <= 1'b1;
            if (bus.bready && !b_pend) early_b <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        return (old & ~m) | (d & m);
    endfunction

    // Issues one command from an idle DUT and checks the full response; exp_lat is the
    // expected number of cycles from the command cycle to the first o_rsp_valid cycle.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold, input int exp_lat,
                           input string tag);
        int          lat;
        logic        busy_ok, stable;
        logic [31:0] exp_data;
        logic [1:0]  exp_st;
        check({tag, "_idle_ready"}, cmd_ready, 1);
        cmd_write = wr; cmd_address = addr; cmd_data = data; cmd_strobe = strb;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        step();
        cmd_valid = 1'b0;
        if (wr) check({tag, "_awv_wv"}, {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b110);
        else    check({tag, "_arv"}, {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b001);
        lat = 1;
        busy_ok = 1'b1;
        while (!rsp_valid && lat < 60) begin
            if (cmd_ready) busy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_latency"}, lat, exp_lat);
        if (wr) begin
            model_mem[addr[7:2]] = merge(model_mem[addr[7:2]], data, strb);
            exp_data = '0;
            exp_st   = bresp_cfg;
        end else begin
            exp_data = rd_ovr_en ? rd_ovr_val : model_mem[addr[7:2]];
            exp_st   = rresp_cfg;
        end
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_status !== exp_st ||
                cmd_ready !== 1'b0) stable = 1'b0;
            step();
        end
        if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
        check({tag, "_busy_not_ready"}, {busy_ok, cmd_ready}, 2'b10);
        check({tag, "_rsp_write"}, rsp_write, wr);
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_status"}, rsp_status, exp_st);
        if (wr) check({tag, "_aw_w_payload"}, {aw_a, w_d, w_s}, {addr, data, strb});
        else    check({tag, "_ar_payload"}, ar_a, addr);
        rsp_ready = 1'b1;
        step();
        check({tag, "_back_idle"}, {cmd_ready, rsp_valid}, 2'b10);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          acc, aw0, w0, lat, mx;
        logic        wr;
        logic [31:0] d;
        logic [3:0]  s;
        logic [AW-1:0] a;
        int          hold;

        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        cmd_data = '0; cmd_strobe = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_axi_valids",
              {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
        check("reset_rsp", {rsp_valid, rsp_write, rsp_status, rsp_data}, '0);
        check("reset_payload", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb,
                                bus.awprot, bus.arprot}, '0);
        rst_n = 1'b1;
        step();

        // minimum-latency write
        run_txn(1'b1, 16'h0000, 32'h0000_00A5, 4'hF, 0, 3, "wr_a5");

        // AW accepted 3 cycles late, W at once
        aw_delay = 3;
        aw0 = aw_hi; w0 = w_hi;
        run_txn(1'b1, 16'h0008, 32'hDEAD_BEEF, 4'hF, 0, 6, "wr_aw_late");
        check("wr_aw_late_awvalid_cycles", aw_hi - aw0, 4);
        check("wr_aw_late_wvalid_cycles", w_hi - w0, 1);
        aw_delay = 0;

        // read with a fixed slave answer
        rd_ovr_en = 1'b1; rd_ovr_val = 32'h1234_5678;
        run_txn(1'b0, 16'h0040, 32'h0, 4'h0, 0, 3, "rd_40");

        // SLVERR read held 5 cycles by the consumer
        rresp_cfg = 2'b10; rd_ovr_val = 32'h0BAD_0BAD;
        run_txn(1'b0, 16'h0044, 32'h0, 4'h0, 5, 3, "rd_slverr");
        rresp_cfg = 2'b00; rd_ovr_en = 1'b0;

        // back-to-back write then read with cmd_valid held high
        rsp_ready = 1'b1;
        cmd_write = 1'b1; cmd_address = 16'h000C; cmd_data = 32'hA1B2_C3D4; cmd_strobe = 4'b0101;
        cmd_valid = 1'b1;
        check("b2b_first_ready", cmd_ready, 1);
        step();
        model_mem[3] = merge(model_mem[3], 32'hA1B2_C3D4, 4'b0101);
        cmd_write = 1'b0;
        acc = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) check("b2b_wr_rsp", {rsp_valid, rsp_write}, 2'b11);
            if (cmd_ready) begin
                acc = k;
                break;
            end
            step();
        end
        check("b2b_second_accept_cycle", acc, 4);
        step();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            step();
            lat++;
        end
        check("b2b_rd_latency", lat, 3);
        check("b2b_rd_data", {rsp_write, rsp_status, rsp_data}, {1'b0, 2'b00, model_mem[3]});
        step();
        rsp_ready = 1'b0;

        // randomized traffic against the memory model
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 15) * 4);
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            hold = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
            mx = (aw_delay > w_delay) ? aw_delay : w_delay;
            lat = wr ? 3 + mx + b_delay : 3 + ar_delay + r_delay;
            run_txn(wr, a, d, s, hold, lat, $sformatf("rnd%0d", n));
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;

        check("no_overlap_ar_aw", overlap, 0);
        check("no_bready_before_aw_w", early_b, 0);

        // asynchronous reset in the middle of a write
        aw_delay = 10; w_delay = 10;
        cmd_write = 1'b1; cmd_address = 16'h0010; cmd_data = 32'h5555_AAAA; cmd_strobe = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("rst_pre_awvalid", bus.awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valids", {bus.awvalid, bus.wvalid, rsp_valid}, 3'b000);
        check("rst_async_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        aw_delay = 0; w_delay = 0;
        step();
        check("rst_release_ready", {cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid}, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
